pmul_arbiter: RTL and testbench



---
 rtl/pmul_arbiter_if.sv | 41 ++++
 rtl/pmul_arbiter.sv | 174 +++++++++++++++++
 tb/tb_pmul_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pmul_arbiter_if.sv
// Signal bundle between the sign/verify requesters, the arbiter and the shared point-multiply engine.
interface pmul_arbiter_if #(
   parameter int W = 256
);
   logic [1:0]   req_valid;
   logic [1:0]   req_ready;
   logic [W-1:0] req0_k;
   logic [W-1:0] req0_px;
   logic [W-1:0] req0_py;
   logic [W-1:0] req1_k;
   logic [W-1:0] req1_px;
   logic [W-1:0] req1_py;
   logic [1:0]   rsp_valid;
   logic [1:0]   rsp_ready;
   logic [W-1:0] rsp_x;
   logic [W-1:0] rsp_y;
   logic         rsp_err;
   logic         eng_rst_n;
   logic [W-1:0] eng_k;
   logic [W-1:0] eng_px;
   logic [W-1:0] eng_py;
   logic [W-1:0] eng_x;
   logic [W-1:0] eng_y;
   logic         eng_done;
   logic         busy;
   logic         grant;

   modport slave (
      input  req_valid, req0_k, req0_px, req0_py, req1_k, req1_px, req1_py,
             rsp_ready, eng_x, eng_y, eng_done,
      output req_ready, rsp_valid, rsp_x, rsp_y, rsp_err,
             eng_rst_n, eng_k, eng_px, eng_py, busy, grant
   );

   modport master (
      output req_valid, req0_k, req0_px, req0_py, req1_k, req1_px, req1_py,
             rsp_ready, eng_x, eng_y, eng_done,
      input  req_ready, rsp_valid, rsp_x, rsp_y, rsp_err,
             eng_rst_n, eng_k, eng_px, eng_py, busy, grant
   );
endinterface

// File: rtl/pmul_arbiter.sv
// Round-robin sharing of one SM2 k*P engine between signer (0) and verifier (1), with
// engine clear sequencing, result capture, watchdog abort and a k==0 bypass.
module pmul_arbiter #(
   parameter int W           = 256,
   parameter int CLR_CYCLES  = 2,
   parameter int TIMEOUT_CYC = 1048576
) (
   input logic           clk,
   input logic           rst_n,
   pmul_arbiter_if.slave bus
);
   localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
   localparam int TW = $clog2(TIMEOUT_CYC);
   localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);
   localparam logic [TW-1:0] WD_LAST  = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_RUN   = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic          grant_q, grant_d;
   logic [CW-1:0] clr_cnt_q, clr_cnt_d;
   logic [TW-1:0] wd_q, wd_d;
   logic          eng_rst_n_q, eng_rst_n_d;
   logic [W-1:0]  eng_k_q, eng_k_d;
   logic [W-1:0]  eng_px_q, eng_px_d;
   logic [W-1:0]  eng_py_q, eng_py_d;
   logic [W-1:0]  rsp_x_q, rsp_x_d;
   logic [W-1:0]  rsp_y_q, rsp_y_d;
   logic          rsp_err_q, rsp_err_d;
   logic          win_s;
   logic [1:0]    req_ready_s;
   logic [W-1:0]  sel_k_s, sel_px_s, sel_py_s;

   // Arbitration winner and its operands; on a tie the requester not served last wins.
   always_comb begin
      win_s = 1'b0;
      if (bus.req_valid == 2'b11) begin
         win_s = ~grant_q;
      end else begin
         win_s = bus.req_valid[1];
      end
      if (win_s) begin
         sel_k_s  = bus.req1_k;
         sel_px_s = bus.req1_px;
         sel_py_s = bus.req1_py;
      end else begin
         sel_k_s  = bus.req0_k;
         sel_px_s = bus.req0_px;
         sel_py_s = bus.req0_py;
      end
   end

   // Next-state and datapath decisions for the accept/clear/run/respond sequence.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      clr_cnt_d   = clr_cnt_q;
      wd_d        = wd_q;
      eng_rst_n_d = eng_rst_n_q;
      eng_k_d     = eng_k_q;
      eng_px_d    = eng_px_q;
      eng_py_d    = eng_py_q;
      rsp_x_d     = rsp_x_q;
      rsp_y_d     = rsp_y_q;
      rsp_err_d   = rsp_err_q;
      req_ready_s = 2'b00;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid != 2'b00) begin
               req_ready_s = win_s ? 2'b10 : 2'b01;
               grant_d     = win_s;
               eng_k_d     = sel_k_s;
               eng_px_d    = sel_px_s;
               eng_py_d    = sel_py_s;
               // The engine never terminates for k==0, so answer without starting it.
               if (sel_k_s == '0) begin
                  state_d   = S_RESP;
                  rsp_x_d   = '0;
                  rsp_y_d   = '0;
                  rsp_err_d = 1'b1;
               end else begin
                  state_d   = S_CLEAR;
                  clr_cnt_d = '0;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CLEAR: begin
            if (clr_cnt_q == CLR_LAST) begin
               state_d     = S_RUN;
               wd_d        = '0;
               eng_rst_n_d = 1'b1;
            end else begin
               clr_cnt_d = clr_cnt_q + CW'(1);
            end
         end
         S_RUN: begin
            if (bus.eng_done) begin
               state_d     = S_RESP;
               rsp_x_d     = bus.eng_x;
               rsp_y_d     = bus.eng_y;
               rsp_err_d   = 1'b0;
               eng_rst_n_d = 1'b0;
            end else if (wd_q == WD_LAST) begin
               state_d     = S_RESP;
               rsp_x_d     = '0;
               rsp_y_d     = '0;
               rsp_err_d   = 1'b1;
               eng_rst_n_d = 1'b0;
            end else begin
               wd_d = wd_q + TW'(1);
            end
         end
         S_RESP: begin
            if (bus.rsp_ready[grant_q]) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RESP;
            end
         end
         default: begin
            state_d     = S_IDLE;
            eng_rst_n_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         grant_q     <= 1'b1;
         clr_cnt_q   <= '0;
         wd_q        <= '0;
         eng_rst_n_q <= 1'b0;
         eng_k_q     <= '0;
         eng_px_q    <= '0;
         eng_py_q    <= '0;
         rsp_x_q     <= '0;
         rsp_y_q     <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         clr_cnt_q   <= clr_cnt_d;
         wd_q        <= wd_d;
         eng_rst_n_q <= eng_rst_n_d;
         eng_k_q     <= eng_k_d;
         eng_px_q    <= eng_px_d;
         eng_py_q    <= eng_py_d;
         rsp_x_q     <= rsp_x_d;
         rsp_y_q     <= rsp_y_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.req_ready = req_ready_s;
   assign bus.rsp_valid = (state_q == S_RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
   assign bus.rsp_x     = rsp_x_q;
   assign bus.rsp_y     = rsp_y_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.eng_rst_n = eng_rst_n_q;
   assign bus.eng_k     = eng_k_q;
   assign bus.eng_px    = eng_px_q;
   assign bus.eng_py    = eng_py_q;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.grant     = grant_q;
endmodule

// File: tb/tb_pmul_arbiter.sv
// Scoreboard bench for pmul_arbiter: queued requesters, a fake engine, and a monitor that
// checks responses, arbitration order and cycle timing against a reference model.
module tb_pmul_arbiter;
   localparam int W   = 256;
   localparam int CLR = 2;
   localparam int TO  = 16;

   typedef struct { logic [W-1:0] k; logic [W-1:0] px; logic [W-1:0] py; } req_t;
   typedef struct { logic [W-1:0] x; logic [W-1:0] y; logic err; } rsp_t;

   logic clk;
   logic rst_n;
   pmul_arbiter_if #(.W(W)) bus ();

   pmul_arbiter #(.W(W), .CLR_CYCLES(CLR), .TIMEOUT_CYC(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   req_t stim_q[2][$];
   rsp_t exp_q[2][$];
   int   grant_log[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   hang_mode = 1'b0;
   int   rr_mode = 0;
   bit   outst = 1'b0;

   logic [W-1:0] gx;
   logic [W-1:0] gy;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_i(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Fake engine result: k=1 yields P itself; other k give a distinct deterministic point.
   function automatic logic [W-1:0] eng_fx(input logic [W-1:0] k, input logic [W-1:0] px);
      return px + k - W'(1);
   endfunction

   function automatic logic [W-1:0] eng_fy(input logic [W-1:0] k, input logic [W-1:0] py);
      return py ^ ((k - W'(1)) << 3);
   endfunction

   function automatic rsp_t model(input req_t q, input bit hang);
      rsp_t e;
      if (q.k == '0 || hang) begin
         e.x = '0; e.y = '0; e.err = 1'b1;
      end else begin
         e.x = eng_fx(q.k, q.px); e.y = eng_fy(q.k, q.py); e.err = 1'b0;
      end
      return e;
   endfunction

   function automatic logic [W-1:0] rnd_w();
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic req_t mk(input logic [W-1:0] k, input logic [W-1:0] px, input logic [W-1:0] py);
      req_t q;
      q.k = k; q.px = px; q.py = py;
      return q;
   endfunction

   // Engine stub: counts a random latency after release from reset, then holds done.
   initial begin : engine_stub
      int cnt;
      int lat;
      logic [W-1:0] k_s, px_s, py_s;
      bus.eng_done = 1'b0; bus.eng_x = '0; bus.eng_y = '0;
      cnt = 0; lat = 1; k_s = '0; px_s = '0; py_s = '0;
      forever begin
         @(posedge clk); #1;
         if (!bus.eng_rst_n) begin
            cnt = 0;
            bus.eng_done = 1'b0;
         end else begin
            if (cnt == 0) begin
               lat = int'($urandom_range(12, 1));
               k_s = bus.eng_k; px_s = bus.eng_px; py_s = bus.eng_py;
            end else begin
               chk("eng_k_stable", bus.eng_k, k_s);
               chk("eng_px_stable", bus.eng_px, px_s);
               chk("eng_py_stable", bus.eng_py, py_s);
            end
            cnt++;
            if (!hang_mode && cnt >= lat) begin
               bus.eng_done = 1'b1;
               bus.eng_x = eng_fx(k_s, px_s);
               bus.eng_y = eng_fy(k_s, py_s);
            end
         end
      end
   end

   // Requester driver: raises queued requests, drops valid after acceptance, drives rsp_ready.
   initial begin : driver
      bit   acc[2];
      req_t it;
      bus.req_valid = 2'b00; bus.rsp_ready = 2'b00;
      bus.req0_k = '0; bus.req0_px = '0; bus.req0_py = '0;
      bus.req1_k = '0; bus.req1_px = '0; bus.req1_py = '0;
      forever begin
         @(negedge clk);
         for (int r = 0; r < 2; r++) acc[r] = rst_n && bus.req_valid[r] && bus.req_ready[r];
         @(posedge clk); #1;
         for (int r = 0; r < 2; r++) if (acc[r]) bus.req_valid[r] = 1'b0;
         for (int r = 0; r < 2; r++) begin
            if (!bus.req_valid[r] && stim_q[r].size() > 0) begin
               it = stim_q[r].pop_front();
               if (r == 0) begin
                  bus.req0_k = it.k; bus.req0_px = it.px; bus.req0_py = it.py;
               end else begin
                  bus.req1_k = it.k; bus.req1_px = it.px; bus.req1_py = it.py;
               end
               exp_q[r].push_back(model(it, hang_mode));
               bus.req_valid[r] = 1'b1;
            end
         end
         case (rr_mode)
            1:       bus.rsp_ready = 2'b11;
            2:       bus.rsp_ready = 2'b01;
            default: bus.rsp_ready = 2'($urandom_range(3, 0));
         endcase
      end
   end

   // Monitor: arbitration model, latency checks, response scoreboard and hold stability.
   initial begin : monitor
      int cyc, acc_cyc, rise_cyc, done_cyc, acc_r, last_g, exp_rise;
      bit acc_k0, acc_hang, prev_eng, hold, was_idle;
      logic [1:0] prev_rv, win_oh;
      logic [W-1:0] hx, hy;
      logic herr;
      rsp_t e;
      cyc = 0; acc_cyc = 0; rise_cyc = -1; done_cyc = -1; acc_r = 0; last_g = 1;
      acc_k0 = 1'b0; acc_hang = 1'b0; prev_eng = 1'b0; hold = 1'b0;
      prev_rv = 2'b00; hx = '0; hy = '0; herr = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            outst = 1'b0; prev_eng = 1'b0; prev_rv = 2'b00; hold = 1'b0; last_g = 1;
         end else begin
            cyc++;
            was_idle = !outst;
            if (bus.req_valid == 2'b11) win_oh = (last_g == 0) ? 2'b10 : 2'b01;
            else win_oh = bus.req_valid;
            if (outst) begin
               chk("busy_op", bus.busy, 1);
               chk("req_ready_busy", bus.req_ready, 0);
            end else begin
               chk("busy_idle", bus.busy, 0);
               chk("req_ready_idle", bus.req_ready, win_oh);
               chk("rsp_valid_idle", bus.rsp_valid, 0);
            end
            if (bus.eng_rst_n && !prev_eng) begin
               rise_cyc = cyc;
               chk_i("eng_start_cycle", cyc, (outst && !acc_k0) ? acc_cyc + CLR + 1 : -1);
            end
            if (outst && bus.eng_done && bus.eng_rst_n && done_cyc < 0) done_cyc = cyc;
            if (outst && bus.rsp_valid != 2'b00 && prev_rv == 2'b00) begin
               exp_rise = acc_k0 ? acc_cyc + 1 : (acc_hang ? rise_cyc + TO : done_cyc + 1);
               chk_i("rsp_rise_cycle", cyc, exp_rise);
               chk("rsp_valid_onehot", bus.rsp_valid, (acc_r == 1) ? 2'b10 : 2'b01);
               chk("grant_out", bus.grant, acc_r);
               chk("eng_rst_n_resp", bus.eng_rst_n, 0);
            end
            if (hold) begin
               chk("hold_x", bus.rsp_x, hx);
               chk("hold_y", bus.rsp_y, hy);
               chk("hold_err", bus.rsp_err, herr);
               chk("hold_valid", bus.rsp_valid, prev_rv);
            end
            if (outst && bus.rsp_valid[acc_r] && bus.rsp_ready[acc_r]) begin
               if (exp_q[acc_r].size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL unexpected_rsp: requester %0d got a response with none expected", acc_r);
               end else begin
                  e = exp_q[acc_r].pop_front();
                  chk("rsp_x", bus.rsp_x, e.x);
                  chk("rsp_y", bus.rsp_y, e.y);
                  chk("rsp_err", bus.rsp_err, e.err);
               end
               outst = 1'b0;
               hold = 1'b0;
            end else begin
               hold = (bus.rsp_valid != 2'b00);
               hx = bus.rsp_x; hy = bus.rsp_y; herr = bus.rsp_err;
            end
            if (was_idle && win_oh != 2'b00) begin
               acc_r = win_oh[1] ? 1 : 0;
               last_g = acc_r;
               grant_log.push_back(acc_r);
               acc_cyc = cyc;
               acc_k0 = (acc_r == 0) ? (bus.req0_k == '0) : (bus.req1_k == '0);
               acc_hang = hang_mode;
               rise_cyc = -1; done_cyc = -1;
               outst = 1'b1;
            end
            prev_eng = bus.eng_rst_n;
            prev_rv = bus.rsp_valid;
         end
      end
   end

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((stim_q[0].size() + stim_q[1].size() + exp_q[0].size() + exp_q[1].size()) != 0
             || bus.req_valid != 2'b00 || outst) begin
         @(posedge clk);
         n++;
         if (n > 3000) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
            break;
         end
      end
      @(posedge clk);
   endtask

   initial begin : watchdog
      #600000;
      $display("FAIL global_timeout: simulation did not finish, required $finish");
      $fatal(1, "global timeout");
   end

   initial begin : main
      int fair_exp[4];
      int n;
      logic [W-1:0] k;
      gx = 256'h32C4AE2C1F1981195F9904466A39C9948FE30BBFF2660BE1715A4589334C74C7;
      gy = 256'hBC3736A2F4F6779C59BDCEE36B692153D0A9877CC62A474002DF32E52139F0A0;
      fair_exp = '{0, 1, 0, 1};
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_eng_rst_n", bus.eng_rst_n, 0);
      chk("rst_grant", bus.grant, 1);
      chk("rst_rsp_x", bus.rsp_x, 0);
      chk("rst_rsp_err", bus.rsp_err, 0);
      chk("rst_eng_k", bus.eng_k, 0);
      chk("rst_req_ready", bus.req_ready, 0);
      #2 rst_n = 1'b1;
      @(posedge clk);

      // Both requesters continuously valid from reset: grants 0,1,0,1.
      grant_log.delete();
      stim_q[0].push_back(mk(W'(2), gx, gy)); stim_q[0].push_back(mk(W'(2), gx, gy));
      stim_q[1].push_back(mk(W'(2), gx, gy)); stim_q[1].push_back(mk(W'(2), gx, gy));
      wait_idle("fair");
      chk_i("fair_count", grant_log.size(), 4);
      for (int i = 0; i < 4 && i < grant_log.size(); i++) chk_i("fair_order", grant_log[i], fair_exp[i]);

      // Single k=1 request on G.
      rr_mode = 1;
      stim_q[0].push_back(mk(W'(1), gx, gy));
      wait_idle("k1");

      // k==0 bypass.
      stim_q[0].push_back(mk('0, rnd_w(), rnd_w()));
      wait_idle("k0");

      // Watchdog abort, then a normal run.
      hang_mode = 1'b1;
      stim_q[0].push_back(mk(W'(5), rnd_w(), rnd_w()));
      wait_idle("hang");
      hang_mode = 1'b0;
      stim_q[1].push_back(mk(W'(1), gx, gy));
      wait_idle("after_hang");

      // Response back-pressure on requester 1 while requester 0 waits.
      rr_mode = 2;
      stim_q[1].push_back(mk(W'(3), rnd_w(), rnd_w()));
      n = 0;
      while (!bus.rsp_valid[1] && n < 200) begin @(posedge clk); n++; end
      chk_i("bp_rsp_seen", n < 200 ? 1 : 0, 1);
      stim_q[0].push_back(mk(W'(4), rnd_w(), rnd_w()));
      repeat (50) @(posedge clk);
      #1;
      chk("bp_busy", bus.busy, 1);
      chk("bp_req_ready", bus.req_ready, 0);
      chk("bp_valid", bus.req_valid, 2'b01);
      grant_log.delete();
      rr_mode = 1;
      wait_idle("bp");
      chk_i("bp_next_grant_count", grant_log.size(), 1);
      if (grant_log.size() > 0) chk_i("bp_next_grant", grant_log[0], 0);

      // Randomized traffic.
      rr_mode = 0;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(3, 0))
            0:       k = '0;
            1:       k = W'($urandom_range(1000, 1));
            default: k = rnd_w() | W'(1);
         endcase
         stim_q[$urandom_range(1, 0)].push_back(mk(k, rnd_w(), rnd_w()));
      end
      wait_idle("random");

      // Asynchronous reset in the middle of a run.
      hang_mode = 1'b1;
      rr_mode = 1;
      stim_q[0].push_back(mk(W'(7), rnd_w(), rnd_w()));
      n = 0;
      while (!bus.eng_rst_n && n < 100) begin @(posedge clk); n++; end
      chk_i("midrun_started", n < 100 ? 1 : 0, 1);
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("mr_rsp_valid", bus.rsp_valid, 0);
      chk("mr_busy", bus.busy, 0);
      chk("mr_eng_rst_n", bus.eng_rst_n, 0);
      chk("mr_rsp_x", bus.rsp_x, 0);
      chk("mr_rsp_y", bus.rsp_y, 0);
      chk("mr_rsp_err", bus.rsp_err, 0);
      chk("mr_eng_k", bus.eng_k, 0);
      chk("mr_eng_px", bus.eng_px, 0);
      chk("mr_grant", bus.grant, 1);
      chk("mr_req_ready", bus.req_ready, 0);
      exp_q[0].delete();
      exp_q[1].delete();
      @(posedge clk);
      #3 rst_n = 1'b1;
      hang_mode = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      chk("post_rst_rsp_valid", bus.rsp_valid, 0);
      chk("post_rst_busy", bus.busy, 0);

      // Normal operation resumes after reset.
      stim_q[1].push_back(mk(W'(1), gx, gy));
      wait_idle("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
